// File: rtl/sys_bus_decoder.sv
// System-bus to eight-port subordinate decoder with single outstanding request.
// Optional WAIT timeout enabled by defining SYS_BUS_DECODER_TIMEOUT_EN.
module sys_bus_decoder #(
  parameter int          DW      = 32,
  parameter int          AW      = 32,
  parameter int          SEL_LSB = 20,
  parameter logic [7:0]  SUB_EN  = 8'hFF
) (
  input  logic              sys_clk_i,
  input  logic              sys_rstn_i,
  input  logic [AW-1:0]     sys_addr_i,
  input  logic [DW-1:0]     sys_wdata_i,
  input  logic [DW/8-1:0]   sys_sel_i,
  input  logic              sys_wen_i,
  input  logic              sys_ren_i,
  output logic [DW-1:0]     sys_rdata_o,
  output logic              sys_err_o,
  output logic              sys_ack_o,
  output logic [AW-1:0]     sub_addr_o,
  output logic [DW-1:0]     sub_wdata_o,
  output logic [DW/8-1:0]   sub_sel_o,
  output logic [7:0]        sub_wen_o,
  output logic [7:0]        sub_ren_o,
  input  logic [8*DW-1:0]   sub_rdata_i,
  input  logic [7:0]        sub_err_i,
  input  logic [7:0]        sub_ack_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_WAIT} state_t;

  state_t              state, state_nx;
  logic [2:0]          idx_q;
  logic                wr_q;
  logic                dis_q;
  logic [SEL_LSB-1:0]  loc_q;
  logic [DW-1:0]       wdata_q;
  logic [DW/8-1:0]     sel_q;

  logic [2:0]          idx_in;
  logic                accept;
  logic                ack_sel;
  logic                err_sel;
  logic [DW-1:0]       rdata_sel;
  logic                done;
  logic                done_err;
  logic [DW-1:0]       done_rdata;
  logic                unused_addr;

  assign idx_in      = sys_addr_i[SEL_LSB +: 3];
  assign accept      = (state == ST_IDLE) && (sys_wen_i || sys_ren_i);
  assign ack_sel     = sub_ack_i[idx_q];
  assign err_sel     = sub_err_i[idx_q];
  assign rdata_sel   = sub_rdata_i[32'(idx_q)*DW +: DW];
  assign unused_addr = ^sys_addr_i[AW-1:SEL_LSB+3];

`ifdef SYS_BUS_DECODER_TIMEOUT_EN
  logic [3:0] cnt;

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i)            cnt <= '0;
    else if (accept)            cnt <= '0;
    else if (state != ST_IDLE)  cnt <= cnt + 4'd1;
  end
`endif

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) state <= ST_IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = SUB_EN[idx_in] ? ST_STROBE : ST_WAIT;
      end
      ST_STROBE: begin
        if (ack_sel) begin
          done       = 1'b1;
          done_err   = err_sel;
          done_rdata = wr_q ? '0 : rdata_sel;
          state_nx   = ST_IDLE;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dis_q) begin
          done     = 1'b1;
          done_err = 1'b1;
          state_nx = ST_IDLE;
        end else if (ack_sel) begin
          done       = 1'b1;
          done_err   = err_sel;
          done_rdata = wr_q ? '0 : rdata_sel;
          state_nx   = ST_IDLE;
`ifdef SYS_BUS_DECODER_TIMEOUT_EN
        // cnt reads 14 in the 15th counted cycle; its increment would reach 15
        end else if (cnt == 4'd14) begin
          done     = 1'b1;
          done_err = 1'b1;
          state_nx = ST_IDLE;
`endif
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      idx_q       <= '0;
      wr_q        <= 1'b0;
      dis_q       <= 1'b0;
      loc_q       <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      sys_ack_o   <= 1'b0;
      sys_err_o   <= 1'b0;
      sys_rdata_o <= '0;
    end else begin
      sys_ack_o <= done;
      if (done) begin
        sys_err_o   <= done_err;
        sys_rdata_o <= done_rdata;
      end
      if (accept) begin
        idx_q   <= idx_in;
        wr_q    <= sys_wen_i;
        dis_q   <= ~SUB_EN[idx_in];
        loc_q   <= sys_addr_i[SEL_LSB-1:0];
        wdata_q <= sys_wdata_i;
        sel_q   <= sys_sel_i;
      end
    end
  end

  assign sub_addr_o  = {{(AW-SEL_LSB){1'b0}}, loc_q};
  assign sub_wdata_o = wdata_q;
  assign sub_sel_o   = sel_q;

  always_comb begin
    sub_wen_o = '0;
    sub_ren_o = '0;
    if (state == ST_STROBE) begin
      if (wr_q) sub_wen_o = 8'd1 << idx_q;
      else      sub_ren_o = 8'd1 << idx_q;
    end
  end

endmodule
